// File: rtl/ebi_rx_deframer_if.sv
// On-die message hand-off port of the EBI receive deframer: one held message
// presented with valid/ready, its channel id and an LSB-aligned payload.
interface ebi_rx_deframer_if #(
  parameter int unsigned CHANNEL_NUM_WIDTH  = 2,
  parameter int unsigned MAX_MESSAGE_LENGTH = 128
);
  logic                          msg_valid;
  logic                          msg_ready;
  logic [CHANNEL_NUM_WIDTH-1:0]  msg_channel;
  logic [MAX_MESSAGE_LENGTH-1:0] msg_payload;

  modport master (
    output msg_valid,
    output msg_channel,
    output msg_payload,
    input  msg_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_channel,
    input  msg_payload,
    output msg_ready
  );
endinterface

// File: rtl/ebi_rx_deframer.sv
// Receive end of the off-die EBI serial link. Deframes start/data/parity/end
// beats, checks group parity, answers with a serial SUCCESS/FAIL credit and
// hands accepted messages to a one-entry holding register.
module ebi_rx_deframer #(
  parameter int unsigned OFF_DIE_WD                        = 8,
  parameter int unsigned CHANNEL_NUM                       = 4,
  parameter int unsigned CHANNEL_NUM_WIDTH                 = 2,
  parameter int unsigned MAX_MESSAGE_LENGTH                = 128,
  parameter int unsigned MAX_MESSAGE_WIDTH                 = 8,
  parameter int unsigned CHANNEL_LENGTH_LIST [CHANNEL_NUM] = '{30, 62, 126, 128},
  parameter int unsigned PARITY_LENGTH                     = 4,
  parameter int unsigned CREDIT_WIDTH                      = 2,
  parameter logic [CREDIT_WIDTH-1:0] SUCCESS               = 2'b01
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [OFF_DIE_WD-1:0] bus_in,
  output logic                  credit_out,
  ebi_rx_deframer_if.master     msg,
  output logic [7:0]            err_cnt
);

  localparam logic [CREDIT_WIDTH-1:0] FailCode = CREDIT_WIDTH'(2'b10);
  localparam int unsigned MaxBeats  =
      (CHANNEL_NUM_WIDTH + MAX_MESSAGE_LENGTH + OFF_DIE_WD - 1) / OFF_DIE_WD;
  localparam int unsigned AsmWidth  = MaxBeats * OFF_DIE_WD;
  localparam int unsigned GrpWidth  = $clog2(PARITY_LENGTH + 1);
  localparam int unsigned CbitWidth = $clog2(CREDIT_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle, StData, StParity, StEnd, StCrStart, StCrBits
  } state_e;

  function automatic logic [MAX_MESSAGE_WIDTH-1:0] beats_for(input int unsigned len);
    return MAX_MESSAGE_WIDTH'((CHANNEL_NUM_WIDTH + len + OFF_DIE_WD - 1) / OFF_DIE_WD);
  endfunction

  state_e                         r_state,   w_state_d;
  logic [AsmWidth-1:0]            r_asm,     w_asm_d;
  logic [OFF_DIE_WD-1:0]          r_xor,     w_xor_d;
  logic [MAX_MESSAGE_WIDTH-1:0]   r_beat,    w_beat_d;
  logic [MAX_MESSAGE_WIDTH-1:0]   r_n,       w_n_d;
  logic [GrpWidth-1:0]            r_grp,     w_grp_d;
  logic                           r_bad,     w_bad_d;
  logic [CREDIT_WIDTH-1:0]        r_code,    w_code_d;
  logic [CbitWidth-1:0]           r_cbit,    w_cbit_d;
  logic                           r_credit,  w_credit_d;
  logic                           r_valid,   w_valid_d;
  logic [CHANNEL_NUM_WIDTH-1:0]   r_hold_ch, w_hold_ch_d;
  logic [MAX_MESSAGE_LENGTH-1:0]  r_hold_pl, w_hold_pl_d;
  logic [7:0]                     r_err,     w_err_d;

  logic [CHANNEL_NUM_WIDTH-1:0]   w_asm_ch;
  logic                           w_bus_ch_ok;
  logic [MAX_MESSAGE_WIDTH-1:0]   w_bus_n;
  logic                           w_asm_ch_ok;
  int unsigned                    w_asm_len;
  logic [MAX_MESSAGE_LENGTH-1:0]  w_len_mask;
  logic [MAX_MESSAGE_WIDTH-1:0]   w_beat_n;
  logic [MAX_MESSAGE_WIDTH-1:0]   w_beat_inc;
  logic [GrpWidth-1:0]            w_grp_inc;
  logic                           w_end_bad;
  logic                           w_accept;

  // The channel id sits in the low bits of beat 0 of the assembly register.
  assign w_asm_ch   = r_asm[CHANNEL_NUM_WIDTH-1:0];
  assign w_beat_inc = r_beat + MAX_MESSAGE_WIDTH'(1);
  assign w_grp_inc  = r_grp + GrpWidth'(1);
  // Beat count is fixed from the bus during beat 0, from the register afterwards.
  assign w_beat_n   = (r_beat == '0) ? w_bus_n : r_n;
  assign w_end_bad  = r_bad | (bus_in != '1);
  assign w_accept   = !w_end_bad && w_asm_ch_ok && (!r_valid || msg.msg_ready);

  // Channel table lookups; unknown ids fall back to entry 0 so the frame is still consumed.
  always_comb begin
    w_bus_ch_ok = 1'b0;
    w_bus_n     = beats_for(CHANNEL_LENGTH_LIST[0]);
    w_asm_ch_ok = 1'b0;
    w_asm_len   = CHANNEL_LENGTH_LIST[0];
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (bus_in[CHANNEL_NUM_WIDTH-1:0] == CHANNEL_NUM_WIDTH'(i)) begin
        w_bus_ch_ok = 1'b1;
        w_bus_n     = beats_for(CHANNEL_LENGTH_LIST[i]);
      end
      if (w_asm_ch == CHANNEL_NUM_WIDTH'(i)) begin
        w_asm_ch_ok = 1'b1;
        w_asm_len   = CHANNEL_LENGTH_LIST[i];
      end
    end
    for (int unsigned b = 0; b < MAX_MESSAGE_LENGTH; b++) begin
      w_len_mask[b] = (b < w_asm_len);
    end
  end

  // Next-state logic for the deframer FSM, credit shifter and holding register.
  always_comb begin
    w_state_d   = r_state;
    w_asm_d     = r_asm;
    w_xor_d     = r_xor;
    w_beat_d    = r_beat;
    w_n_d       = r_n;
    w_grp_d     = r_grp;
    w_bad_d     = r_bad;
    w_code_d    = r_code;
    w_cbit_d    = r_cbit;
    w_credit_d  = r_credit;
    w_valid_d   = r_valid & ~msg.msg_ready;
    w_hold_ch_d = r_hold_ch;
    w_hold_pl_d = r_hold_pl;
    w_err_d     = r_err;

    unique case (r_state)
      StIdle: begin
        if (!bus_in[0]) begin
          w_state_d = StData;
          w_asm_d   = '0;
          w_xor_d   = '0;
          w_beat_d  = '0;
          w_grp_d   = '0;
          w_bad_d   = 1'b0;
        end
      end
      StData: begin
        for (int unsigned b = 0; b < MaxBeats; b++) begin
          if (r_beat == MAX_MESSAGE_WIDTH'(b)) w_asm_d[b*OFF_DIE_WD +: OFF_DIE_WD] = bus_in;
        end
        if (r_beat == '0) begin
          w_n_d = w_bus_n;
          if (!w_bus_ch_ok) w_bad_d = 1'b1;
        end
        w_xor_d  = r_xor ^ bus_in;
        w_beat_d = w_beat_inc;
        w_grp_d  = w_grp_inc;
        if (w_grp_inc == GrpWidth'(PARITY_LENGTH) || w_beat_inc == w_beat_n) begin
          w_state_d = StParity;
        end
      end
      StParity: begin
        if (bus_in != r_xor) w_bad_d = 1'b1;
        w_xor_d   = '0;
        w_grp_d   = '0;
        w_state_d = (r_beat == r_n) ? StEnd : StData;
      end
      StEnd: begin
        w_bad_d    = w_end_bad;
        w_credit_d = 1'b0;
        w_cbit_d   = '0;
        w_state_d  = StCrStart;
        if (w_accept) begin
          w_code_d    = SUCCESS;
          w_valid_d   = 1'b1;
          w_hold_ch_d = w_asm_ch;
          w_hold_pl_d = r_asm[CHANNEL_NUM_WIDTH +: MAX_MESSAGE_LENGTH] & w_len_mask;
        end else begin
          w_code_d = FailCode;
          if (r_err != 8'hFF) w_err_d = r_err + 8'd1;
        end
      end
      StCrStart: begin
        w_credit_d = r_code[0];
        w_code_d   = r_code >> 1;
        w_cbit_d   = CbitWidth'(1);
        w_state_d  = StCrBits;
      end
      StCrBits: begin
        if (r_cbit == CbitWidth'(CREDIT_WIDTH)) begin
          w_credit_d = 1'b1;
          w_state_d  = StIdle;
        end else begin
          w_credit_d = r_code[0];
          w_code_d   = r_code >> 1;
          w_cbit_d   = r_cbit + CbitWidth'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any frame or credit in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_asm     <= '0;
      r_xor     <= '0;
      r_beat    <= '0;
      r_n       <= '0;
      r_grp     <= '0;
      r_bad     <= 1'b0;
      r_code    <= '0;
      r_cbit    <= '0;
      r_credit  <= 1'b1;
      r_valid   <= 1'b0;
      r_hold_ch <= '0;
      r_hold_pl <= '0;
      r_err     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_asm     <= w_asm_d;
      r_xor     <= w_xor_d;
      r_beat    <= w_beat_d;
      r_n       <= w_n_d;
      r_grp     <= w_grp_d;
      r_bad     <= w_bad_d;
      r_code    <= w_code_d;
      r_cbit    <= w_cbit_d;
      r_credit  <= w_credit_d;
      r_valid   <= w_valid_d;
      r_hold_ch <= w_hold_ch_d;
      r_hold_pl <= w_hold_pl_d;
      r_err     <= w_err_d;
    end
  end

  // Pad bits of the last beat are captured but never read.
  if (AsmWidth > CHANNEL_NUM_WIDTH + MAX_MESSAGE_LENGTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^r_asm[AsmWidth-1:CHANNEL_NUM_WIDTH+MAX_MESSAGE_LENGTH];
  end

  assign credit_out      = r_credit;
  assign err_cnt         = r_err;
  assign msg.msg_valid   = r_valid;
  assign msg.msg_channel = r_hold_ch;
  assign msg.msg_payload = r_hold_pl;

endmodule

// File: tb/tb_ebi_rx_deframer.sv
// Bench for ebi_rx_deframer: builds frames from the link rules, drives them on
// negedge like the far end, and checks credit, hand-off and error count.
module tb_ebi_rx_deframer;
  localparam int unsigned WD = 8;
  localparam int unsigned CW = 2;
  localparam int unsigned ML = 128;

  int unsigned lens [4] = '{30, 62, 126, 128};

  logic          clk = 1'b0;
  logic          rstn;
  logic [WD-1:0] bus_in;
  logic          credit_out;
  logic [7:0]    err_cnt;

  ebi_rx_deframer_if #(.CHANNEL_NUM_WIDTH(CW), .MAX_MESSAGE_LENGTH(ML)) mif ();

  ebi_rx_deframer dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus_in     (bus_in),
    .credit_out (credit_out),
    .msg        (mif),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   frame_q [$];
  int           par_idx [$];
  int           dat_idx [$];

  // Reference state of the consumer-visible side.
  logic         exp_valid;
  logic [1:0]   exp_ch;
  logic [127:0] exp_pl;
  int           exp_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Frame = start, data beats with a parity beat after each group of 4 (or a
  // shorter last group), then an all-ones end beat. Bits beyond the channel
  // length and the beat padding carry random junk.
  task automatic build(input int ch, input logic [127:0] pl);
    logic [255:0] bits;
    logic [7:0]   acc;
    int           n;
    int           grp;
    bits = {$urandom, $urandom, $urandom, $urandom, 128'b0};
    bits[129:2] = pl;
    bits[1:0]   = 2'(ch);
    n = (CW + lens[ch] + WD - 1) / WD;
    frame_q.delete();
    par_idx.delete();
    dat_idx.delete();
    frame_q.push_back({7'($urandom), 1'b0});
    acc = '0;
    grp = 0;
    for (int d = 0; d < n; d++) begin
      if (d > 0) dat_idx.push_back(frame_q.size());
      frame_q.push_back(bits[d*WD +: WD]);
      acc = acc ^ bits[d*WD +: WD];
      grp++;
      if (grp == 4 || d == n - 1) begin
        par_idx.push_back(frame_q.size());
        frame_q.push_back(acc);
        acc = '0;
        grp = 0;
      end
    end
    frame_q.push_back(8'hFF);
  endtask

  // kind: 0 clean, 1 parity beat ^= cval, 2 end beat = cval, 3 one data bit flipped.
  // Called just after a negedge; returns just after a negedge with the DUT idle.
  task automatic run_frame(input string tag, input int ch, input logic [127:0] pl,
                           input int kind, input logic [7:0] cval, input logic rdy);
    logic         accept;
    logic         exp_v0;
    logic         v0;
    logic [1:0]   ch0;
    logic [127:0] pl0;
    logic [127:0] new_pl;
    logic [1:0]   code;
    logic [3:0]   seq;
    logic [3:0]   exp_seq;
    int           idx;
    build(ch, pl);
    if (kind == 1) begin
      idx = par_idx[$urandom_range(0, par_idx.size() - 1)];
      frame_q[idx] = frame_q[idx] ^ cval;
    end else if (kind == 2) begin
      frame_q[frame_q.size() - 1] = cval;
    end else if (kind == 3) begin
      idx = dat_idx[$urandom_range(0, dat_idx.size() - 1)];
      frame_q[idx] = frame_q[idx] ^ 8'(1 << $urandom_range(0, 7));
    end
    new_pl = pl & ({128{1'b1}} >> (128 - lens[ch]));
    accept = (kind == 0) && (!exp_valid || rdy);
    mif.msg_ready = rdy;

    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == frame_q.size() - 1) begin
        chk({tag, ".pre_valid"}, 128'(mif.msg_valid), 128'(exp_valid & ~rdy));
      end
      bus_in = frame_q[i];
      @(negedge clk);
    end
    // Credit window; the link is noisy with start-like beats that must be ignored.
    seq[0] = credit_out;
    v0     = mif.msg_valid;
    ch0    = mif.msg_channel;
    pl0    = mif.msg_payload;
    bus_in = {7'($urandom), 1'b0};
    @(negedge clk);
    seq[1] = credit_out;
    bus_in = {7'($urandom), 1'b0};
    @(negedge clk);
    seq[2] = credit_out;
    bus_in = {7'($urandom), 1'b0};
    @(negedge clk);
    seq[3] = credit_out;
    bus_in = '1;

    code = accept ? 2'b01 : 2'b10;
    if (!accept) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    exp_seq = {1'b1, code[1], code[0], 1'b0};
    exp_v0  = accept | (exp_valid & ~rdy);
    if (accept) begin
      exp_ch = 2'(ch);
      exp_pl = new_pl;
    end
    chk({tag, ".credit"}, 128'(seq), 128'(exp_seq));
    chk({tag, ".valid"}, 128'(v0), 128'(exp_v0));
    if (exp_v0) begin
      chk({tag, ".channel"}, 128'(ch0), 128'(exp_ch));
      chk({tag, ".payload"}, pl0, exp_pl);
    end
    chk({tag, ".err_cnt"}, 128'(err_cnt), 128'(exp_err));
    exp_valid = exp_v0 & ~rdy;
  endtask

  initial begin
    logic [127:0] pl_b;
    logic [127:0] pl_e;
    int           kind;
    logic [7:0]   cval;

    rstn          = 1'b1;
    bus_in        = '1;
    mif.msg_ready = 1'b0;
    exp_valid     = 1'b0;
    exp_ch        = '0;
    exp_pl        = '0;
    exp_err       = 0;
    #1 rstn = 1'b0;
    #1;
    chk("rst.credit",  128'(credit_out),      128'(1));
    chk("rst.valid",   128'(mif.msg_valid),   128'(0));
    chk("rst.channel", 128'(mif.msg_channel), 128'(0));
    chk("rst.payload", mif.msg_payload,       128'(0));
    chk("rst.err_cnt", 128'(err_cnt),         128'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_frame("t1_ch1", 1, 128'hA5A5_0F0F_1234_5678, 0, 8'h00, 1'b1);
    run_frame("t2_par_lane3", 0, rnd128(), 1, 8'h08, 1'b1);

    pl_b = rnd128();
    run_frame("t3_first", 0, rnd128(), 0, 8'h00, 1'b0);
    run_frame("t3_full", 0, pl_b, 0, 8'h00, 1'b0);
    run_frame("t3_resend", 0, pl_b, 0, 8'h00, 1'b1);

    pl_e = rnd128();
    run_frame("t4_end_fe", 1, pl_e, 2, 8'hFE, 1'b1);
    run_frame("t4_end_ff", 1, pl_e, 0, 8'h00, 1'b1);

    run_frame("t5_ch3", 3, rnd128() | (128'b1 << 127), 0, 8'h00, 1'b1);
    run_frame("t5_ch2", 2, rnd128(), 0, 8'h00, 1'b1);

    for (int r = 0; r < 40; r++) begin
      kind = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      cval = (kind == 2) ? 8'($urandom_range(0, 254)) : 8'($urandom_range(1, 255));
      run_frame("rnd", int'($urandom_range(0, 3)), rnd128(), kind, cval,
                1'($urandom_range(0, 1)));
    end

    // Reset mid-frame with a message held and a nonzero error count.
    run_frame("t6_hold", 2, rnd128(), 0, 8'h00, 1'b0);
    run_frame("t6_fail", 0, rnd128(), 3, 8'h00, 1'b0);
    build(1, rnd128());
    for (int i = 0; i < 7; i++) begin
      bus_in = frame_q[i];
      @(negedge clk);
    end
    bus_in = frame_q[7];
    #2 rstn = 1'b0;
    #1;
    chk("t6.credit",  128'(credit_out),      128'(1));
    chk("t6.valid",   128'(mif.msg_valid),   128'(0));
    chk("t6.channel", 128'(mif.msg_channel), 128'(0));
    chk("t6.payload", mif.msg_payload,       128'(0));
    chk("t6.err_cnt", 128'(err_cnt),         128'(0));
    @(negedge clk);
    bus_in = '1;
    @(negedge clk);
    rstn      = 1'b1;
    exp_valid = 1'b0;
    exp_err   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6.no_credit", 128'(credit_out), 128'(1));
    end
    run_frame("t6_clean", 1, rnd128(), 0, 8'h00, 1'b1);

    for (int i = 0; i < 256; i++) begin
      run_frame("t7_sat", 0, rnd128(), 2, 8'hFE, 1'b1);
    end
    run_frame("t7_after", 0, rnd128(), 0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
